// File: rtl/csr_irq_ctrl.sv
// Purpose: machine-mode CSR file plus interrupt / WFI sleep controller for the 5-stage core.
// Latency: CSR reads are combinational; writes, trap/mret updates and all strobes are registered (1 cycle).
// Backpressure: `stall` defers trap and mret entry; the sleeping state ignores `stall` and holds the pipe via wfi_stall.
//
// Ports:
//   clk, rst                        clock, synchronous active-high reset
//   stall                           global memory-wait stall
//   csr_raddr / csr_rdata           EX-stage combinational CSR read (unmapped reads return 0)
//   csr_wr_en_WB/_addr_WB/_result_WB  WB-stage CSR write (data already RW/RS/RC resolved)
//   WFI, mret, resume_pc            MEM-stage WFI / MRET indications and PC to save on trap
//   instr_retire                    one instruction retired this cycle (counter build only)
//   ext_irq, timer_irq              interrupt request levels
//   interrupt_pulse                 one-cycle trap-entry strobe
//   redirect, redirect_pc           one-cycle PC redirect (trap -> mtvec, mret -> mepc)
//   wfi_stall                       holds the pipeline while sleeping
//
// Build option: define CSR_COUNTERS_EN to add the 64-bit mcycle/minstret counters.
module csr_irq_ctrl #(
    parameter int               XLEN        = 32,
    parameter logic [XLEN-1:0]  RESET_MTVEC = 32'h0001_0000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic [11:0]      csr_raddr,
    output logic [XLEN-1:0]  csr_rdata,
    input  logic             csr_wr_en_WB,
    input  logic [11:0]      csr_addr_WB,
    input  logic [XLEN-1:0]  csr_result_WB,
    input  logic             WFI,
    input  logic             mret,
    input  logic [XLEN-1:0]  resume_pc,
    input  logic             instr_retire,
    input  logic             ext_irq,
    input  logic             timer_irq,
    output logic             interrupt_pulse,
    output logic             redirect,
    output logic [XLEN-1:0]  redirect_pc,
    output logic             wfi_stall
);

    localparam logic [11:0] ADDR_MSTATUS  = 12'h300;
    localparam logic [11:0] ADDR_MIE      = 12'h304;
    localparam logic [11:0] ADDR_MTVEC    = 12'h305;
    localparam logic [11:0] ADDR_MEPC     = 12'h341;
    localparam logic [11:0] ADDR_MCAUSE   = 12'h342;
    localparam logic [11:0] ADDR_MIP      = 12'h344;
`ifdef CSR_COUNTERS_EN
    localparam logic [11:0] ADDR_MCYCLE   = 12'hB00;
    localparam logic [11:0] ADDR_MINSTRET = 12'hB02;
    localparam logic [11:0] ADDR_MCYCLEH  = 12'hB80;
    localparam logic [11:0] ADDR_MINSTRETH = 12'hB82;
`endif

    localparam logic [XLEN-1:0] CAUSE_EXT = {1'b1, {(XLEN-5){1'b0}}, 4'd11};
    localparam logic [XLEN-1:0] CAUSE_TMR = {1'b1, {(XLEN-5){1'b0}}, 4'd7};

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        SLEEP = 2'd1,
        TRAP  = 2'd2
    } state_t;

    // Architectural state; only implemented bits are stored.
    logic            mst_mie_q;
    logic            mst_mpie_q;
    logic [1:0]      mst_mpp_q;
    logic            mie_mtie_q;
    logic            mie_meie_q;
    logic [XLEN-1:2] mtvec_q;
    logic [XLEN-1:2] mepc_q;
    logic [XLEN-1:0] mcause_q;

    state_t          state_q, state_nxt;

    logic            pend;
    logic            take;
    logic [XLEN-1:0] trap_cause;
    logic            trap_entry;
    logic            mret_do;
    logic            pulse_nxt;
    logic            redirect_nxt;
    logic [XLEN-1:0] redirect_pc_nxt;
    logic            wfi_stall_nxt;

    // Interrupt qualification; external has priority over timer.
    assign pend       = (mie_meie_q & ext_irq) | (mie_mtie_q & timer_irq);
    assign take       = pend & mst_mie_q;
    assign trap_cause = (mie_meie_q & ext_irq) ? CAUSE_EXT : CAUSE_TMR;

    // ---------------- FSM: state register + registered strobes ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= RUN;
            interrupt_pulse <= 1'b0;
            redirect        <= 1'b0;
            redirect_pc     <= '0;
            wfi_stall       <= 1'b0;
        end else begin
            state_q         <= state_nxt;
            interrupt_pulse <= pulse_nxt;
            redirect        <= redirect_nxt;
            redirect_pc     <= redirect_pc_nxt;
            wfi_stall       <= wfi_stall_nxt;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_nxt = state_q;
        case (state_q)
            RUN: begin
                if (take && !stall) begin
                    state_nxt = TRAP;
                end else if (WFI && !pend) begin
                    state_nxt = SLEEP;
                end
            end
            SLEEP: begin
                // Any enabled pending source wakes; MIE only decides whether we also trap.
                if (pend) begin
                    state_nxt = take ? TRAP : RUN;
                end
            end
            TRAP:    state_nxt = RUN;
            default: state_nxt = RUN;
        endcase
    end

    // ---------------- FSM: outputs (next values of the registered strobes) ----------------
    always_comb begin
        trap_entry      = 1'b0;
        mret_do         = 1'b0;
        case (state_q)
            RUN: begin
                trap_entry = take && !stall;
                mret_do    = mret && !stall && !take;
            end
            SLEEP:   trap_entry = take;
            default: begin
                trap_entry = 1'b0;
                mret_do    = 1'b0;
            end
        endcase

        pulse_nxt       = trap_entry;
        redirect_nxt    = trap_entry | mret_do;
        redirect_pc_nxt = '0;
        if (trap_entry) begin
            redirect_pc_nxt = {mtvec_q, 2'b00};
        end else if (mret_do) begin
            redirect_pc_nxt = {mepc_q, 2'b00};
        end
        wfi_stall_nxt   = (state_nxt == SLEEP);
    end

    // ---------------- CSR state ----------------
    // Software write is applied first; the hardware trap/mret update that follows
    // in the same block overrides it for any CSR they both touch.
    always_ff @(posedge clk) begin
        if (rst) begin
            mst_mie_q  <= 1'b0;
            mst_mpie_q <= 1'b0;
            mst_mpp_q  <= 2'b00;
            mie_mtie_q <= 1'b0;
            mie_meie_q <= 1'b0;
            mtvec_q    <= RESET_MTVEC[XLEN-1:2];
            mepc_q     <= '0;
            mcause_q   <= '0;
        end else begin
            if (csr_wr_en_WB) begin
                case (csr_addr_WB)
                    ADDR_MSTATUS: begin
                        mst_mie_q  <= csr_result_WB[3];
                        mst_mpie_q <= csr_result_WB[7];
                        mst_mpp_q  <= csr_result_WB[12:11];
                    end
                    ADDR_MIE: begin
                        mie_mtie_q <= csr_result_WB[7];
                        mie_meie_q <= csr_result_WB[11];
                    end
                    ADDR_MTVEC:  mtvec_q  <= csr_result_WB[XLEN-1:2];
                    ADDR_MEPC:   mepc_q   <= csr_result_WB[XLEN-1:2];
                    ADDR_MCAUSE: mcause_q <= csr_result_WB;
                    default: ;
                endcase
            end
            if (trap_entry) begin
                mepc_q     <= resume_pc[XLEN-1:2];
                mcause_q   <= trap_cause;
                mst_mpie_q <= mst_mie_q;
                mst_mie_q  <= 1'b0;
                mst_mpp_q  <= 2'b11;
            end else if (mret_do) begin
                mst_mie_q  <= mst_mpie_q;
                mst_mpie_q <= 1'b1;
                mst_mpp_q  <= 2'b11;
            end
        end
    end

`ifdef CSR_COUNTERS_EN
    logic [63:0] mcycle_q;
    logic [63:0] minstret_q;

    // A software write to either half replaces that cycle's increment.
    always_ff @(posedge clk) begin
        if (rst) begin
            mcycle_q   <= '0;
            minstret_q <= '0;
        end else begin
            if (csr_wr_en_WB && csr_addr_WB == ADDR_MCYCLE) begin
                mcycle_q[31:0]  <= csr_result_WB[31:0];
            end else if (csr_wr_en_WB && csr_addr_WB == ADDR_MCYCLEH) begin
                mcycle_q[63:32] <= csr_result_WB[31:0];
            end else begin
                mcycle_q <= mcycle_q + 64'd1;
            end

            if (csr_wr_en_WB && csr_addr_WB == ADDR_MINSTRET) begin
                minstret_q[31:0]  <= csr_result_WB[31:0];
            end else if (csr_wr_en_WB && csr_addr_WB == ADDR_MINSTRETH) begin
                minstret_q[63:32] <= csr_result_WB[31:0];
            end else if (instr_retire) begin
                minstret_q <= minstret_q + 64'd1;
            end
        end
    end

    logic unused_bits;
    assign unused_bits = ^resume_pc[1:0];
`else
    logic unused_bits;
    assign unused_bits = ^{resume_pc[1:0], instr_retire};
`endif

    // ---------------- Combinational read port ----------------
    always_comb begin
        csr_rdata = '0;
        case (csr_raddr)
            ADDR_MSTATUS: begin
                csr_rdata[3]     = mst_mie_q;
                csr_rdata[7]     = mst_mpie_q;
                csr_rdata[12:11] = mst_mpp_q;
            end
            ADDR_MIE: begin
                csr_rdata[7]  = mie_mtie_q;
                csr_rdata[11] = mie_meie_q;
            end
            ADDR_MTVEC:  csr_rdata = {mtvec_q, 2'b00};
            ADDR_MEPC:   csr_rdata = {mepc_q, 2'b00};
            ADDR_MCAUSE: csr_rdata = mcause_q;
            ADDR_MIP: begin
                csr_rdata[7]  = timer_irq;
                csr_rdata[11] = ext_irq;
            end
`ifdef CSR_COUNTERS_EN
            ADDR_MCYCLE:    csr_rdata = XLEN'(mcycle_q[31:0]);
            ADDR_MCYCLEH:   csr_rdata = XLEN'(mcycle_q[63:32]);
            ADDR_MINSTRET:  csr_rdata = XLEN'(minstret_q[31:0]);
            ADDR_MINSTRETH: csr_rdata = XLEN'(minstret_q[63:32]);
`endif
            default: csr_rdata = '0;
        endcase
    end

endmodule

// File: tb/tb_csr_irq_ctrl.sv
// Purpose: self-checking bench for csr_irq_ctrl (CSR read/write table plus trap, mret, WFI, stall and conflict sequences).
// Latency: inputs driven 1ns after posedge, registered outputs checked in the same window.
// Backpressure: exercises `stall` deferral of trap entry.
module tb_csr_irq_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic [11:0] csr_raddr;
    logic [31:0] csr_rdata;
    logic        csr_wr_en_WB;
    logic [11:0] csr_addr_WB;
    logic [31:0] csr_result_WB;
    logic        WFI;
    logic        mret;
    logic [31:0] resume_pc;
    logic        instr_retire;
    logic        ext_irq;
    logic        timer_irq;
    logic        interrupt_pulse;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        wfi_stall;

    always #5 clk = ~clk;

    csr_irq_ctrl dut (
        .clk             (clk),
        .rst             (rst),
        .stall           (stall),
        .csr_raddr       (csr_raddr),
        .csr_rdata       (csr_rdata),
        .csr_wr_en_WB    (csr_wr_en_WB),
        .csr_addr_WB     (csr_addr_WB),
        .csr_result_WB   (csr_result_WB),
        .WFI             (WFI),
        .mret            (mret),
        .resume_pc       (resume_pc),
        .instr_retire    (instr_retire),
        .ext_irq         (ext_irq),
        .timer_irq       (timer_irq),
        .interrupt_pulse (interrupt_pulse),
        .redirect        (redirect),
        .redirect_pc     (redirect_pc),
        .wfi_stall       (wfi_stall)
    );

    int vectors     = 0;
    int miscompares = 0;
    int pulse_cnt   = 0;

    // Counts every cycle in which the trap strobe is high.
    always @(posedge clk) begin
        if (interrupt_pulse === 1'b1) pulse_cnt++;
    end

    typedef struct {
        logic [11:0] addr;
        logic [31:0] wdata;
        logic        ext;
        logic        tmr;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [11];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_csr(input string nm, input logic [11:0] a, input logic [31:0] exp);
        csr_raddr = a;
        #1;
        chk(nm, csr_rdata, exp);
    endtask

    task automatic csr_wr(input logic [11:0] a, input logic [31:0] d);
        csr_wr_en_WB  = 1'b1;
        csr_addr_WB   = a;
        csr_result_WB = d;
        tick();
        csr_wr_en_WB  = 1'b0;
    endtask

    initial begin
        int p0;

        vecs[0]  = '{12'h300, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'h0000_1888};
        vecs[1]  = '{12'h300, 32'h0000_0000, 1'b0, 1'b0, 32'h0000_0000};
        vecs[2]  = '{12'h304, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'h0000_0880};
        vecs[3]  = '{12'h304, 32'h0000_0000, 1'b0, 1'b0, 32'h0000_0000};
        vecs[4]  = '{12'h305, 32'h1234_5677, 1'b0, 1'b0, 32'h1234_5674};
        vecs[5]  = '{12'h341, 32'hABCD_EF03, 1'b0, 1'b0, 32'hABCD_EF00};
        vecs[6]  = '{12'h342, 32'h8000_000B, 1'b0, 1'b0, 32'h8000_000B};
        vecs[7]  = '{12'h344, 32'hFFFF_FFFF, 1'b1, 1'b1, 32'h0000_0880};
        vecs[8]  = '{12'h344, 32'h0000_0000, 1'b0, 1'b1, 32'h0000_0080};
        vecs[9]  = '{12'h123, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0000_0000};
        vecs[10] = '{12'h305, 32'h0001_0003, 1'b0, 1'b0, 32'h0001_0000};

        rst = 1'b1; stall = 1'b0; csr_raddr = '0; csr_wr_en_WB = 1'b0;
        csr_addr_WB = '0; csr_result_WB = '0; WFI = 1'b0; mret = 1'b0;
        resume_pc = '0; instr_retire = 1'b0; ext_irq = 1'b0; timer_irq = 1'b0;

        // ---- reset state ----
        tick(); tick();
        rst = 1'b0;
        chk("rst_pulse",    {31'd0, interrupt_pulse}, 32'd0);
        chk("rst_redirect", {31'd0, redirect},        32'd0);
        chk("rst_rpc",      redirect_pc,              32'd0);
        chk("rst_wfi",      {31'd0, wfi_stall},       32'd0);
        chk_csr("rst_mtvec",   12'h305, 32'h0001_0000);
        chk_csr("rst_mstatus", 12'h300, 32'h0);
        chk_csr("rst_mcause",  12'h342, 32'h0);
        tick();

        // ---- table: CSR write / readback ----
        for (int i = 0; i < 11; i++) begin
            ext_irq   = vecs[i].ext;
            timer_irq = vecs[i].tmr;
            csr_wr(vecs[i].addr, vecs[i].wdata);
            chk_csr($sformatf("vec%0d_%h", i, vecs[i].addr), vecs[i].addr, vecs[i].exp);
            ext_irq   = 1'b0;
            timer_irq = 1'b0;
        end

        // ---- trap entry and mret ----
        csr_wr(12'h304, 32'h800);
        csr_wr(12'h300, 32'h8);
        resume_pc = 32'h200;
        ext_irq   = 1'b1;
        tick();
        ext_irq   = 1'b0;
        chk("trap_pulse",    {31'd0, interrupt_pulse}, 32'd1);
        chk("trap_redirect", {31'd0, redirect},        32'd1);
        chk("trap_rpc",      redirect_pc,              32'h0001_0000);
        chk_csr("trap_mepc",    12'h341, 32'h200);
        chk_csr("trap_mcause",  12'h342, 32'h8000_000B);
        chk_csr("trap_mstatus", 12'h300, 32'h1880);
        tick();
        chk("trap_gap_pulse",    {31'd0, interrupt_pulse}, 32'd0);
        chk("trap_gap_redirect", {31'd0, redirect},        32'd0);
        tick();
        mret = 1'b1;
        tick();
        mret = 1'b0;
        chk("mret_redirect", {31'd0, redirect},        32'd1);
        chk("mret_rpc",      redirect_pc,              32'h200);
        chk("mret_pulse",    {31'd0, interrupt_pulse}, 32'd0);
        chk_csr("mret_mstatus", 12'h300, 32'h1888);
        tick();
        chk("mret_one_cycle", {31'd0, redirect}, 32'd0);

        // ---- WFI wake without trap (MIE=0, MTIE=1) ----
        csr_wr(12'h300, 32'h0);
        csr_wr(12'h304, 32'h80);
        p0  = pulse_cnt;
        WFI = 1'b1;
        tick();
        WFI = 1'b0;
        chk("wfi_sleep0", {31'd0, wfi_stall}, 32'd1);
        for (int i = 0; i < 3; i++) tick();
        chk("wfi_sleep3", {31'd0, wfi_stall}, 32'd1);
        timer_irq = 1'b1;
        tick();
        chk("wfi_wake",       {31'd0, wfi_stall},       32'd0);
        chk("wfi_wake_pulse", {31'd0, interrupt_pulse}, 32'd0);
        timer_irq = 1'b0;
        tick();
        chk("wfi_no_trap_cnt", pulse_cnt - p0, 32'd0);

        // ---- WFI wake with trap (MIE=1, timer) ----
        csr_wr(12'h300, 32'h8);
        resume_pc = 32'h480;
        WFI = 1'b1;
        tick();
        WFI = 1'b0;
        tick();
        chk("wfit_sleep", {31'd0, wfi_stall}, 32'd1);
        timer_irq = 1'b1;
        tick();
        timer_irq = 1'b0;
        chk("wfit_pulse", {31'd0, interrupt_pulse}, 32'd1);
        chk("wfit_wfi",   {31'd0, wfi_stall},       32'd0);
        chk("wfit_rpc",   redirect_pc,              32'h0001_0000);
        chk_csr("wfit_mcause", 12'h342, 32'h8000_0007);
        chk_csr("wfit_mepc",   12'h341, 32'h480);
        tick();

        // ---- stall deferral ----
        p0      = pulse_cnt;
        stall   = 1'b1;
        ext_irq = 1'b1;
        csr_wr(12'h304, 32'h800);
        csr_wr(12'h300, 32'h8);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk($sformatf("stall_nopulse%0d", i), {31'd0, interrupt_pulse}, 32'd0);
        end
        stall = 1'b0;
        tick();
        chk("stall_pulse", {31'd0, interrupt_pulse}, 32'd1);
        ext_irq = 1'b0;
        tick();
        chk("stall_pulse_end", {31'd0, interrupt_pulse}, 32'd0);
        chk("stall_pulse_cnt", pulse_cnt - p0, 32'd1);

        // ---- simultaneous ext+timer, and trap vs software mepc write ----
        csr_wr(12'h304, 32'h880);
        csr_wr(12'h300, 32'h8);
        resume_pc     = 32'h300;
        ext_irq       = 1'b1;
        timer_irq     = 1'b1;
        csr_wr_en_WB  = 1'b1;
        csr_addr_WB   = 12'h341;
        csr_result_WB = 32'h44;
        tick();
        csr_wr_en_WB  = 1'b0;
        ext_irq       = 1'b0;
        timer_irq     = 1'b0;
        chk("simul_pulse", {31'd0, interrupt_pulse}, 32'd1);
        chk_csr("simul_mcause", 12'h342, 32'h8000_000B);
        chk_csr("simul_mepc",   12'h341, 32'h300);
        tick();

`ifdef CSR_COUNTERS_EN
        // ---- counters ----
        csr_wr(12'hB80, 32'h7);
        csr_wr(12'hB00, 32'hFFFF_FFFF);
        chk_csr("mcycle_lo_wr", 12'hB00, 32'hFFFF_FFFF);
        chk_csr("mcycle_hi_wr", 12'hB80, 32'h7);
        tick();
        chk_csr("mcycle_lo_wrap", 12'hB00, 32'h0);
        chk_csr("mcycle_hi_inc",  12'hB80, 32'h8);
        csr_wr(12'hB02, 32'h0);
        csr_wr(12'hB82, 32'h0);
        instr_retire = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        instr_retire = 1'b0;
        chk_csr("minstret_lo", 12'hB02, 32'd10);
        chk_csr("minstret_hi", 12'hB82, 32'd0);
`else
        // ---- counter addresses absent ----
        csr_wr(12'hB00, 32'h5);
        chk_csr("nocnt_mcycle",   12'hB00, 32'h0);
        instr_retire = 1'b1;
        tick();
        instr_retire = 1'b0;
        chk_csr("nocnt_minstret", 12'hB02, 32'h0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
